// File: rtl/result_writeback_pkg.sv
// Shared constants and types for the result write-back block.
package result_writeback_pkg;
  localparam int LINE_W     = 1024;
  localparam int ADDR_W     = 64;
  localparam int LINE_SHIFT = 7;
  localparam int TAG_W_DEF  = 8;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/wb_credit_counter.sv
// Outstanding-write counter; can_issue also reserves a slot for the entry
// already waiting in the holding register.
module wb_credit_counter #(
  parameter int MAX_OUTSTANDING = 32,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  input  logic pending,
  output logic can_issue
);
  logic [CW-1:0] count_r;
  logic [CW:0]   proj_s;

  // Outstanding count; simultaneous inc/dec cancel, underflow is blocked
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= '0;
    end else if (inc && !dec) begin
      count_r <= count_r + CW'(1);
    end else if (dec && !inc && (count_r != '0)) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Projected occupancy including the pending issue
  always_comb begin
    proj_s    = {1'b0, count_r} + {{CW{1'b0}}, pending};
    can_issue = (proj_s < (CW+1)'(MAX_OUTSTANDING));
  end
endmodule

// File: rtl/result_writeback.sv
// Drains matrix-multiply result lines into 128-byte host write commands and
// tracks their completion against a credit limit.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 32,
  parameter int LINE_BYTES      = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       total_lines,
  input  logic              buf_rdempty,
  input  logic [LINE_W-1:0] buf_q,
  output logic              buf_rdreq,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [TAG_W-1:0]  cmd_tag,
  output logic [LINE_W-1:0] cmd_data,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic              rsp_ok,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int ADDR_SHIFT = (LINE_BYTES == (1 << LINE_SHIFT)) ? LINE_SHIFT : $clog2(LINE_BYTES);

  state_t              state_r, state_nx;
  logic [ADDR_W-1:0]   base_r;
  logic [31:0]         total_r, issued_r, acked_r;
  logic                hold_valid_r;
  logic [LINE_W-1:0]   hold_data_r;
  logic [ADDR_W-1:0]   hold_addr_r;
  logic [TAG_W-1:0]    hold_tag_r;
  logic                busy_r, done_r, error_r;
  logic                start_ok_s, active_s, accept_s, load_s, rsp_take_s, can_issue_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic                rsp_tag_unused;

  // Responses are counted, not matched, so the tag carries no state here
  assign rsp_tag_unused = ^rsp_tag;

  assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign accept_s    = hold_valid_r && cmd_ready;
  assign rsp_take_s  = rsp_valid && active_s;
  assign next_addr_s = base_r + ({32'd0, issued_r} << ADDR_SHIFT);
  assign load_s      = !rst && (state_r == ST_RUN) && (!hold_valid_r || cmd_ready) &&
                       !buf_rdempty && (issued_r < total_r) && can_issue_s;

  assign buf_rdreq = load_s;
  assign cmd_valid = hold_valid_r;
  assign cmd_addr  = hold_addr_r;
  assign cmd_tag   = hold_tag_r;
  assign cmd_data  = hold_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

  wb_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok_s),
    .inc       (accept_s),
    .dec       (rsp_take_s),
    .pending   (hold_valid_r),
    .can_issue (can_issue_s)
  );

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_nx = (total_lines == 32'd0) ? ST_DONE : ST_RUN;
        end else begin
          state_nx = state_r;
        end
      end
      ST_RUN: begin
        if ((issued_r == total_r) && !hold_valid_r) begin
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (acked_r == total_r) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, job parameters, progress counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      base_r   <= '0;
      total_r  <= 32'd0;
      issued_r <= 32'd0;
      acked_r  <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (start_ok_s) begin
        base_r   <= base_addr;
        total_r  <= total_lines;
        issued_r <= 32'd0;
        acked_r  <= 32'd0;
        error_r  <= 1'b0;
        done_r   <= (total_lines == 32'd0);
        busy_r   <= (total_lines != 32'd0);
      end else begin
        if (load_s) begin
          issued_r <= issued_r + 32'd1;
        end
        if (rsp_take_s) begin
          acked_r <= acked_r + 32'd1;
          if (!rsp_ok) begin
            error_r <= 1'b1;
          end
        end
        if ((state_r == ST_DRAIN) && (state_nx == ST_DONE)) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
      end
    end
  end

  // Single-entry holding register feeding the command interface
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= '0;
      hold_addr_r  <= '0;
      hold_tag_r   <= '0;
    end else if (load_s) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= buf_q;
      hold_addr_r  <= next_addr_s;
      hold_tag_r   <= issued_r[TAG_W-1:0];
    end else if (accept_s) begin
      hold_valid_r <= 1'b0;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end
endmodule

// File: tb/tb_result_writeback.sv
// Directed + randomized bench for result_writeback against a queue-based model
// of the output buffer, the host command stream and the response channel.
module tb_result_writeback;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [63:0]   base_addr;
  logic [31:0]   total_lines;
  logic          buf_rdempty;
  logic [1023:0] buf_q;
  logic          buf_rdreq, cmd_valid, cmd_ready;
  logic [63:0]   cmd_addr;
  logic [7:0]    cmd_tag;
  logic [1023:0] cmd_data;
  logic          rsp_valid, rsp_ok;
  logic [7:0]    rsp_tag;
  logic          busy, done, error;

  result_writeback #(.TAG_W(8), .MAX_OUTSTANDING(MAXO), .LINE_BYTES(128)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .total_lines(total_lines),
    .buf_rdempty(buf_rdempty), .buf_q(buf_q), .buf_rdreq(buf_rdreq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ok(rsp_ok),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] tag; } rsp_t;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  logic [1023:0] bufq[$];
  logic [1023:0] expq[$];
  rsp_t          rspq[$];
  int            exp_idx, responded, fail_tag, ready_mode, stall_left, rsp_hold_until;
  bit            gap;
  logic [63:0]   exp_base;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, advance the models.
  task automatic tick();
    logic pop, rsp_now;
    buf_rdempty = (bufq.size() == 0) || (gap && cyc[0]);
    buf_q = (bufq.size() != 0) ? bufq[0] : '0;
    case (ready_mode)
      0: cmd_ready = 1'b1;
      1: begin
        if (cmd_valid && cmd_tag == 8'd1 && stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
        end else cmd_ready = 1'b1;
      end
      2: cmd_ready = ($urandom_range(0, 3) != 0);
      default: cmd_ready = 1'b0;
    endcase
    rsp_now = 1'b0;
    if (cyc >= rsp_hold_until && rspq.size() != 0 && rspq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_tag = rspq[0].tag;
      rsp_ok = (int'(rspq[0].tag) != fail_tag);
      void'(rspq.pop_front());
      rsp_now = 1'b1;
    end else begin
      rsp_valid = 1'b0;
      rsp_tag = 8'($urandom);
      rsp_ok = 1'($urandom);
    end
    @(negedge clk);
    pop = buf_rdreq;
    if (buf_rdreq) chk("rdreq_while_empty", buf_rdempty, 1'b0);
    if (cmd_valid) begin
      if (exp_idx < expq.size()) begin
        chk("cmd_addr", cmd_addr, exp_base + 64'(exp_idx) * 64'd128);
        chk("cmd_tag", cmd_tag, 8'(exp_idx));
        chk("cmd_data", cmd_data, expq[exp_idx]);
      end else begin
        chk("extra_cmd", cmd_valid, 1'b0);
      end
      if (cmd_ready) begin
        exp_idx++;
        rspq.push_back('{cyc + 2, 8'(exp_idx - 1)});
        chk("credit_limit", (exp_idx - responded) <= MAXO, 1'b1);
      end
    end
    if (rsp_now) responded++;
    @(posedge clk);
    #1;
    if (pop && bufq.size() != 0) void'(bufq.pop_front());
    cyc++;
  endtask

  task automatic prep(input logic [63:0] base, input int n, input int ftag,
                      input int rmode, input bit g, input int hold);
    logic [1023:0] line;
    bufq.delete(); expq.delete(); rspq.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 32; w++) line[w*32 +: 32] = $urandom;
      bufq.push_back(line);
      expq.push_back(line);
    end
    exp_idx = 0; responded = 0; exp_base = base; fail_tag = ftag;
    ready_mode = rmode; stall_left = 5; gap = g;
    base_addr = base; total_lines = n; start = 1'b1;
    rsp_hold_until = cyc + hold;
    tick();
    start = 1'b0;
    base_addr = {$urandom, $urandom};
    total_lines = $urandom_range(0, 3);
  endtask

  task automatic run_job(input logic [63:0] base, input int n, input int ftag,
                         input int rmode, input bit g, input int hold, input bit poke);
    bit got_done = 1'b0;
    prep(base, n, ftag, rmode, g, hold);
    chk("busy_after_start", busy, 1'b1);
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (poke && k == 5) begin
        start = 1'b1;
        total_lines = 32'd0;
      end
      tick();
      start = 1'b0;
      if (hold > 0 && k == hold - 3) chk("credit_stall_count", exp_idx, (n < MAXO) ? n : MAXO);
      got_done = done;
    end
    chk("done", done, 1'b1);
    chk("accepted_count", exp_idx, n);
    chk("responses_before_done", responded, n);
    chk("error_flag", error, (ftag >= 0 && ftag < n));
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_lines = '0;
    buf_rdempty = 1'b1; buf_q = '0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_ok = 1'b0;
    exp_idx = 0; responded = 0; fail_tag = -1; ready_mode = 0; stall_left = 0;
    rsp_hold_until = 0; gap = 1'b0; exp_base = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_cmd_valid", cmd_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_rdreq", buf_rdreq, 1'b0);

    // basic job
    run_job(64'h1000, 4, -1, 0, 1'b0, 0, 1'b0);
    // a failing response while DONE must be ignored
    rspq.push_back('{cyc, 8'd0});
    fail_tag = 0;
    tick();
    chk("rsp_in_done_error", error, 1'b0);
    chk("rsp_in_done_done", done, 1'b1);

    // backpressure on the second command
    run_job({$urandom, $urandom} & ~64'h7f, 6, -1, 1, 1'b0, 0, 1'b0);
    // credit limit with responses withheld
    run_job({$urandom, $urandom} & ~64'h7f, 10, -1, 0, 1'b0, 20, 1'b0);
    // buffer empty every other cycle
    run_job({$urandom, $urandom} & ~64'h7f, 10, -1, 0, 1'b1, 0, 1'b0);
    // failed write on tag 2
    run_job({$urandom, $urandom} & ~64'h7f, 5, 2, 0, 1'b0, 0, 1'b0);

    // zero-length job
    prep(64'h2000, 0, -1, 0, 1'b0, 0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_error", error, 1'b0);
    repeat (2) tick();
    chk("zero_no_cmd", cmd_valid, 1'b0);

    // randomized jobs with random ready, gaps and an ignored start while busy
    for (int j = 0; j < 3; j++) begin
      int n = $urandom_range(6, 20);
      run_job({$urandom, $urandom} & ~64'h7f, n, ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 1) : -1,
              2, 1'($urandom), 0, 1'b1);
    end

    // reset mid-job, then a clean restart
    prep(64'h8000, 8, -1, 0, 1'b0, 1000);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      ok = (exp_idx >= 3);
    end
    chk("three_issued", exp_idx, 3);
    ready_mode = 3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cmd_valid", cmd_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    bufq.delete();
    fail_tag = 0;
    rsp_hold_until = cyc;
    repeat (4) tick();
    chk("stale_rsp_error", error, 1'b0);
    chk("stale_rsp_done", done, 1'b0);
    run_job(64'h9000, 5, -1, 0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
